// File: rtl/memory_arbiter_if.sv
// Bundles the requester ports, response outputs and memory_unit command interface of memory_arbiter.
// slave is the arbiter's view; master is the view of whatever drives the requesters and memory_unit.
interface memory_arbiter_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 64
);
   logic              a_req;
   logic [1:0]        a_func;
   logic [ADDR_W-1:0] a_addr1;
   logic [ADDR_W-1:0] a_addr2;
   logic [DATA_W-1:0] a_wdata;
   logic              a_ack;

   logic              b_req;
   logic [1:0]        b_func;
   logic [ADDR_W-1:0] b_addr1;
   logic [ADDR_W-1:0] b_addr2;
   logic [DATA_W-1:0] b_wdata;
   logic              b_ack;

   logic [DATA_W-1:0] rsp_data1;
   logic [DATA_W-1:0] rsp_data2;
   logic [ADDR_W-1:0] rsp_free;
   logic              gc_done;
   logic [ADDR_W-1:0] gc_root;

   logic [1:0]        mu_func;
   logic              mu_execute;
   logic [ADDR_W-1:0] mu_address1;
   logic [ADDR_W-1:0] mu_address2;
   logic [DATA_W-1:0] mu_write_data;
   logic              mu_gc_ready;
   logic              mu_is_ready;
   logic              mu_gc;
   logic [DATA_W-1:0] mu_read_data1;
   logic [DATA_W-1:0] mu_read_data2;
   logic [ADDR_W-1:0] mu_free_addr;

   modport slave (
      input  a_req, a_func, a_addr1, a_addr2, a_wdata,
      input  b_req, b_func, b_addr1, b_addr2, b_wdata,
      input  mu_is_ready, mu_gc, mu_read_data1, mu_read_data2, mu_free_addr,
      output a_ack, b_ack, rsp_data1, rsp_data2, rsp_free, gc_done, gc_root,
      output mu_func, mu_execute, mu_address1, mu_address2, mu_write_data, mu_gc_ready
   );

   modport master (
      output a_req, a_func, a_addr1, a_addr2, a_wdata,
      output b_req, b_func, b_addr1, b_addr2, b_wdata,
      output mu_is_ready, mu_gc, mu_read_data1, mu_read_data2, mu_free_addr,
      input  a_ack, b_ack, rsp_data1, rsp_data2, rsp_free, gc_done, gc_root,
      input  mu_func, mu_execute, mu_address1, mu_address2, mu_write_data, mu_gc_ready
   );
endinterface

// File: rtl/memory_arbiter.sv
// Round-robin arbiter of two requesters onto memory_unit, one command in flight, GC handshake with reissue.
// Requests are held by the ports until their one-cycle ack; no new grant while memory_unit is busy or in GC.
module memory_arbiter #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 64
) (
   input logic             clk,
   input logic             rst,
   memory_arbiter_if.slave bus
);
   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_ISSUE   = 3'd1;
   localparam logic [2:0] S_BUSY    = 3'd2;
   localparam logic [2:0] S_GC_REQ  = 3'd3;
   localparam logic [2:0] S_REISSUE = 3'd4;

   localparam logic [1:0] F_GET_FREE = 2'd2;
   localparam logic       PORT_A     = 1'b0;

   logic [2:0]        r_state;
   logic              r_busy_first;
   logic              r_owner;
   logic              r_rr_last;
   logic              r_has_cmd;
   logic [1:0]        r_func;
   logic [ADDR_W-1:0] r_addr1;
   logic [ADDR_W-1:0] r_addr2;
   logic [DATA_W-1:0] r_wdata;
   logic              r_a_ack;
   logic              r_b_ack;
   logic              r_gc_done;
   logic [ADDR_W-1:0] r_gc_root;
   logic [ADDR_W-1:0] r_rsp_free;
   logic [DATA_W-1:0] r_rsp_data1;
   logic [DATA_W-1:0] r_rsp_data2;

   logic              w_can_grant;
   logic              w_grant_b;
   logic [1:0]        w_sel_func;
   logic [ADDR_W-1:0] w_sel_addr1;
   logic [ADDR_W-1:0] w_sel_addr2;
   logic [DATA_W-1:0] w_sel_wdata;

   // Grants are blocked during an ack cycle: the served port still holds its request then.
   always_comb begin
      w_can_grant = bus.mu_is_ready && !bus.mu_gc && (bus.a_req || bus.b_req)
                    && !r_a_ack && !r_b_ack;
      w_grant_b   = bus.b_req && (!bus.a_req || (r_rr_last == PORT_A));
      w_sel_func  = w_grant_b ? bus.b_func  : bus.a_func;
      w_sel_addr1 = w_grant_b ? bus.b_addr1 : bus.a_addr1;
      w_sel_addr2 = w_grant_b ? bus.b_addr2 : bus.a_addr2;
      w_sel_wdata = w_grant_b ? bus.b_wdata : bus.a_wdata;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_busy_first <= 1'b0;
         r_owner      <= 1'b0;
         r_rr_last    <= 1'b1;
         r_has_cmd    <= 1'b0;
         r_func       <= '0;
         r_addr1      <= '0;
         r_addr2      <= '0;
         r_wdata      <= '0;
         r_a_ack      <= 1'b0;
         r_b_ack      <= 1'b0;
         r_gc_done    <= 1'b0;
         r_gc_root    <= '0;
         r_rsp_free   <= '0;
         r_rsp_data1  <= '0;
         r_rsp_data2  <= '0;
      end else begin
         r_a_ack   <= 1'b0;
         r_b_ack   <= 1'b0;
         r_gc_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.mu_gc) begin
                  r_state <= S_GC_REQ;
               end else if (w_can_grant) begin
                  r_owner   <= w_grant_b;
                  r_rr_last <= w_grant_b;
                  r_func    <= w_sel_func;
                  r_addr1   <= w_sel_addr1;
                  r_addr2   <= w_sel_addr2;
                  r_wdata   <= w_sel_wdata;
                  r_has_cmd <= 1'b1;
                  r_state   <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               r_busy_first <= 1'b1;
               r_state      <= S_BUSY;
            end
            S_BUSY: begin
               // is_ready lags execute by a cycle, so the first BUSY cycle cannot signal completion.
               if (r_busy_first) begin
                  r_busy_first <= 1'b0;
               end else if (bus.mu_is_ready) begin
                  if (bus.mu_gc) begin
                     r_state <= S_GC_REQ;
                  end else begin
                     r_rsp_data1 <= bus.mu_read_data1;
                     r_rsp_data2 <= bus.mu_read_data2;
                     if (r_func == F_GET_FREE) begin
                        r_rsp_free <= bus.mu_free_addr;
                     end
                     r_a_ack   <= ~r_owner;
                     r_b_ack   <= r_owner;
                     r_has_cmd <= 1'b0;
                     r_state   <= S_IDLE;
                  end
               end
            end
            S_GC_REQ: begin
               if (!bus.mu_gc) begin
                  r_gc_root <= bus.mu_read_data1[ADDR_W-1:0];
                  r_gc_done <= 1'b1;
                  r_state   <= r_has_cmd ? S_REISSUE : S_IDLE;
               end
            end
            S_REISSUE: begin
               if (bus.mu_is_ready) begin
                  r_state <= S_ISSUE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      bus.a_ack         = r_a_ack;
      bus.b_ack         = r_b_ack;
      bus.rsp_data1     = r_rsp_data1;
      bus.rsp_data2     = r_rsp_data2;
      bus.rsp_free      = r_rsp_free;
      bus.gc_done       = r_gc_done;
      bus.gc_root       = r_gc_root;
      bus.mu_func       = r_func;
      bus.mu_address1   = r_addr1;
      bus.mu_address2   = r_addr2;
      bus.mu_write_data = r_wdata;
      bus.mu_execute    = (r_state == S_ISSUE);
      bus.mu_gc_ready   = (r_state == S_GC_REQ);
   end
endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: two requester agents, a behavioural memory_unit with GC, and a per-port scoreboard.
`timescale 1ns/1ps
module tb_memory_arbiter;
   localparam int ADDR_W = 10;
   localparam int DATA_W = 64;
   localparam logic [1:0] F_GET  = 2'd0;
   localparam logic [1:0] F_SET  = 2'd1;
   localparam logic [1:0] F_FREE = 2'd2;
   localparam int MAX_MEM = 64;
   localparam logic [ADDR_W-1:0] FREE_INIT = 10'd16;
   localparam logic [ADDR_W-1:0] GC_FREE   = 10'd8;
   localparam logic [DATA_W-1:0] VX = 64'hDEAD_BEEF_0000_0005;
   localparam logic [DATA_W-1:0] VY = 64'hCAFE_F00D_0000_0006;

   typedef struct {
      logic [1:0]        func;
      logic [ADDR_W-1:0] a1;
      logic [ADDR_W-1:0] a2;
      logic [DATA_W-1:0] wd;
      bit                chk_d;
      logic [DATA_W-1:0] d1;
      logic [DATA_W-1:0] d2;
      bit                chk_f;
      logic [ADDR_W-1:0] fr;
   } cmd_t;

   typedef struct {
      bit   port;
      cmd_t c;
   } vec_t;

   logic clk;
   logic rst;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   memory_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();
   memory_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (.clk(clk), .rst(rst), .bus(bus));

   int n_chk = 0;
   int n_fail = 0;
   int exec_cnt = 0;
   int gc_cnt = 0;
   int gcr_cnt = 0;
   int ack_cnt = 0;
   bit ack_log[$];
   cmd_t q_a[$];
   cmd_t q_b[$];
   cmd_t exp_a[$];
   cmd_t exp_b[$];
   logic [ADDR_W-1:0] exp_root;
   logic [ADDR_W-1:0] root_val;
   logic gc_kick;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic cmd_t mk(input logic [1:0] f, input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2,
                               input logic [DATA_W-1:0] wd, input bit cd, input logic [DATA_W-1:0] d1,
                               input logic [DATA_W-1:0] d2, input bit cf, input logic [ADDR_W-1:0] fr);
      cmd_t c;
      c.func = f; c.a1 = a1; c.a2 = a2; c.wd = wd;
      c.chk_d = cd; c.d1 = d1; c.d2 = d2; c.chk_f = cf; c.fr = fr;
      return c;
   endfunction

   // Behavioural memory_unit: two-cycle command latency, bump allocator, GC on overflow or on gc_kick.
   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
   logic [ADDR_W-1:0] free_ptr;
   int m_cnt;
   int m_gcc;
   logic [1:0] m_func;
   logic [ADDR_W-1:0] m_a1, m_a2;
   logic [DATA_W-1:0] m_wd;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.mu_is_ready   <= 1'b1;
         bus.mu_gc         <= 1'b0;
         bus.mu_read_data1 <= '0;
         bus.mu_read_data2 <= '0;
         bus.mu_free_addr  <= '0;
         free_ptr <= FREE_INIT;
         m_cnt <= 0; m_gcc <= 0;
         m_func <= '0; m_a1 <= '0; m_a2 <= '0; m_wd <= '0;
      end else if (bus.mu_gc) begin
         if (bus.mu_gc_ready) begin
            if (m_gcc == 2) begin
               bus.mu_gc <= 1'b0;
               bus.mu_read_data1 <= DATA_W'(root_val);
               free_ptr <= GC_FREE;
               m_gcc <= 0;
            end else begin
               m_gcc <= m_gcc + 1;
            end
         end
      end else if (gc_kick) begin
         bus.mu_gc <= 1'b1;
      end else if (bus.mu_execute && bus.mu_is_ready) begin
         bus.mu_is_ready <= 1'b0;
         m_cnt <= 1;
         m_func <= bus.mu_func; m_a1 <= bus.mu_address1; m_a2 <= bus.mu_address2; m_wd <= bus.mu_write_data;
      end else if (!bus.mu_is_ready) begin
         if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
         end else begin
            bus.mu_is_ready <= 1'b1;
            case (m_func)
               F_GET: begin
                  bus.mu_read_data1 <= mem[m_a1];
                  bus.mu_read_data2 <= mem[m_a2];
               end
               F_SET: mem[m_a1] <= m_wd;
               F_FREE: begin
                  if (DATA_W'(free_ptr) + m_wd > 64'(MAX_MEM)) begin
                     bus.mu_gc <= 1'b1;
                  end else begin
                     bus.mu_free_addr <= free_ptr;
                     free_ptr <= free_ptr + m_wd[ADDR_W-1:0];
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // Requester agents: keep req high while commands remain queued, reload on ack.
   initial begin
      cmd_t c;
      bus.a_req = 0; bus.a_func = 0; bus.a_addr1 = 0; bus.a_addr2 = 0; bus.a_wdata = 0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            bus.a_req = 0;
            exp_a.delete();
         end else if (!bus.a_req || bus.a_ack) begin
            if (q_a.size() > 0) begin
               c = q_a.pop_front();
               bus.a_func = c.func; bus.a_addr1 = c.a1; bus.a_addr2 = c.a2; bus.a_wdata = c.wd;
               exp_a.push_back(c);
               bus.a_req = 1;
            end else begin
               bus.a_req = 0;
            end
         end
      end
   end

   initial begin
      cmd_t c;
      bus.b_req = 0; bus.b_func = 0; bus.b_addr1 = 0; bus.b_addr2 = 0; bus.b_wdata = 0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            bus.b_req = 0;
            exp_b.delete();
         end else if (!bus.b_req || bus.b_ack) begin
            if (q_b.size() > 0) begin
               c = q_b.pop_front();
               bus.b_func = c.func; bus.b_addr1 = c.a1; bus.b_addr2 = c.a2; bus.b_wdata = c.wd;
               exp_b.push_back(c);
               bus.b_req = 1;
            end else begin
               bus.b_req = 0;
            end
         end
      end
   end

   task automatic score(input bit port);
      cmd_t c;
      ack_log.push_back(port);
      if (port ? (exp_b.size() == 0) : (exp_a.size() == 0)) begin
         n_chk++; n_fail++;
         $display("FAIL spurious_ack: port %0d acked with no outstanding request (t=%0t)", port, $time);
         return;
      end
      c = port ? exp_b.pop_front() : exp_a.pop_front();
      if (c.chk_d) begin
         check("rsp_data1", bus.rsp_data1, c.d1);
         check("rsp_data2", bus.rsp_data2, c.d2);
      end
      if (c.chk_f) check("rsp_free", 64'(bus.rsp_free), 64'(c.fr));
   endtask

   always @(negedge clk) begin
      if (rst) begin
         if (bus.mu_execute) exec_cnt++;
         if (bus.mu_gc_ready) gcr_cnt++;
         if (bus.gc_done) begin
            gc_cnt++;
            check("gc_root", 64'(bus.gc_root), 64'(exp_root));
         end
         if (bus.a_ack || bus.b_ack) begin
            ack_cnt++;
            check("ack_onehot", 64'(bus.a_ack & bus.b_ack), 64'd0);
            if (bus.a_ack) score(1'b0);
            if (bus.b_ack) score(1'b1);
         end
      end
   end

   task automatic wait_idle(input string nm, input int budget);
      int n = 0;
      while ((q_a.size() != 0 || q_b.size() != 0 || exp_a.size() != 0 || exp_b.size() != 0
              || bus.a_req || bus.b_req) && n < budget) begin
         @(negedge clk);
         n++;
      end
      n_chk++;
      if (n >= budget) begin
         n_fail++;
         $display("FAIL %s: not idle after %0d cycles, expected completion", nm, budget);
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached before completion");
      $fatal(1, "watchdog");
   end

   vec_t tbl[8];
   int e0, g0, a0, r0, n;

   initial begin
      rst = 1'b0; gc_kick = 1'b0; root_val = '0; exp_root = '0;
      tbl[0] = '{1'b0, mk(F_SET,  10'd5, 10'd0, VX,     0, 0, 0, 0, 0)};
      tbl[1] = '{1'b0, mk(F_SET,  10'd6, 10'd0, VY,     0, 0, 0, 0, 0)};
      tbl[2] = '{1'b0, mk(F_GET,  10'd5, 10'd6, 64'd0,  1, VX, VY, 0, 0)};
      tbl[3] = '{1'b1, mk(F_GET,  10'd6, 10'd5, 64'd0,  1, VY, VX, 0, 0)};
      tbl[4] = '{1'b0, mk(F_FREE, 10'd0, 10'd0, 64'd2,  0, 0, 0, 1, 10'd16)};
      tbl[5] = '{1'b1, mk(F_FREE, 10'd0, 10'd0, 64'd2,  0, 0, 0, 1, 10'd18)};
      tbl[6] = '{1'b0, mk(F_FREE, 10'd0, 10'd0, 64'd30, 0, 0, 0, 1, 10'd20)};
      tbl[7] = '{1'b1, mk(F_GET,  10'd5, 10'd5, 64'd0,  1, VX, VX, 0, 0)};

      repeat (3) @(negedge clk);
      check("rst_acks", 64'({bus.a_ack, bus.b_ack, bus.gc_done}), 64'd0);
      check("rst_mu_ctl", 64'({bus.mu_execute, bus.mu_gc_ready, bus.mu_func}), 64'd0);
      check("rst_rsp", bus.rsp_data1 | bus.rsp_data2 | 64'(bus.rsp_free) | 64'(bus.gc_root), 64'd0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      e0 = exec_cnt;
      foreach (tbl[i]) begin
         @(posedge clk); #1;
         if (tbl[i].port) q_b.push_back(tbl[i].c); else q_a.push_back(tbl[i].c);
         wait_idle("vector", 60);
      end
      check("exec_per_cmd", 64'(exec_cnt - e0), 64'd8);

      // Allocation of 20 at pointer 50 overflows 64: GC, relocation, single reissue.
      root_val = 10'h155; exp_root = 10'h155;
      g0 = gc_cnt; e0 = exec_cnt; a0 = ack_cnt; r0 = gcr_cnt;
      @(posedge clk); #1;
      q_a.push_back(mk(F_FREE, 10'd0, 10'd0, 64'd20, 0, 0, 0, 1, GC_FREE));
      wait_idle("gc_overflow", 100);
      check("gc_done_count", 64'(gc_cnt - g0), 64'd1);
      check("gc_ready_seen", 64'(gcr_cnt > r0), 64'd1);
      check("gc_exec_count", 64'(exec_cnt - e0), 64'd2);
      check("gc_ack_count", 64'(ack_cnt - a0), 64'd1);
      @(posedge clk); #1;
      q_b.push_back(mk(F_FREE, 10'd0, 10'd0, 64'd2, 0, 0, 0, 1, 10'd28));
      wait_idle("post_gc_free", 60);

      // memory_unit raises gc with no command of ours outstanding.
      root_val = 10'h0AA; exp_root = 10'h0AA;
      g0 = gc_cnt; e0 = exec_cnt; a0 = ack_cnt;
      @(negedge clk); gc_kick = 1'b1;
      @(negedge clk); gc_kick = 1'b0;
      repeat (20) @(negedge clk);
      check("idle_gc_done", 64'(gc_cnt - g0), 64'd1);
      check("idle_gc_noack", 64'(ack_cnt - a0), 64'd0);
      check("idle_gc_noexec", 64'(exec_cnt - e0), 64'd0);
      @(posedge clk); #1;
      q_a.push_back(mk(F_GET, 10'd6, 10'd5, 64'd0, 1, VY, VX, 0, 0));
      wait_idle("after_idle_gc", 60);

      // Reset while BUSY with a SET in flight.
      @(posedge clk); #1;
      q_a.push_back(mk(F_SET, 10'd7, 10'd3, 64'h1234_5678_9ABC_DEF0, 0, 0, 0, 0, 0));
      n = 0;
      while (!bus.mu_execute && n < 50) begin @(negedge clk); n++; end
      check("rst_busy_reach_issue", 64'(n < 50), 64'd1);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_busy_mu_func", 64'(bus.mu_func), 64'd0);
      check("rst_busy_mu_addr", 64'({bus.mu_address1, bus.mu_address2}), 64'd0);
      check("rst_busy_mu_wdata", bus.mu_write_data, 64'd0);
      check("rst_busy_rsp", bus.rsp_data1 | bus.rsp_data2, 64'd0);
      check("rst_busy_ctl", 64'({bus.a_ack, bus.b_ack, bus.mu_execute, bus.mu_gc_ready, bus.gc_done}), 64'd0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // Both ports request together and hold: A first after reset, then strict alternation.
      ack_log.delete();
      @(posedge clk); #1;
      q_a.push_back(mk(F_SET, 10'd10, 10'd0, 64'hA0, 0, 0, 0, 0, 0));
      q_a.push_back(mk(F_SET, 10'd11, 10'd0, 64'hA1, 0, 0, 0, 0, 0));
      q_b.push_back(mk(F_SET, 10'd12, 10'd0, 64'hB0, 0, 0, 0, 0, 0));
      q_b.push_back(mk(F_SET, 10'd13, 10'd0, 64'hB1, 0, 0, 0, 0, 0));
      wait_idle("rr_pair", 150);
      check("rr_pair_count", 64'(ack_log.size()), 64'd4);
      for (int i = 0; i < 4 && i < ack_log.size(); i++) check("rr_pair_order", 64'(ack_log[i]), 64'(i % 2));
      @(posedge clk); #1;
      q_a.push_back(mk(F_GET, 10'd11, 10'd12, 64'd0, 1, 64'hA1, 64'hB0, 0, 0));
      wait_idle("rr_readback", 60);

      // B holds its request throughout; A arrives one cycle later and re-requests after every ack.
      ack_log.delete();
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) q_b.push_back(mk(F_SET, 10'(20 + i), 10'd0, 64'(i), 0, 0, 0, 0, 0));
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) q_a.push_back(mk(F_SET, 10'(30 + i), 10'd0, 64'(i), 0, 0, 0, 0, 0));
      wait_idle("no_starve", 200);
      check("no_starve_count", 64'(ack_log.size()), 64'd6);
      for (int i = 0; i < 6 && i < ack_log.size(); i++) check("no_starve_order", 64'(ack_log[i]), 64'((i + 1) % 2));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
